// File: rtl/instruction_fetch_stage_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch stage.
package fetch_pkg;
    typedef enum logic {FETCH = 1'b0, HELD = 1'b1} fetchState_t;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: request/response handshake between fetch stage and instruction memory.
interface instruction_fetch_stage_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    modport master (output imemReq, imemAddr, input imemReady, imemData);
    modport slave  (input imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// if_id_register: IF/ID pipeline register; bubble beats load, otherwise holds.
module if_id_register
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] inPcAdded,
    input  logic [31:0] inInstruction,
    output logic [31:0] outPcAdded,
    output logic [31:0] outInstruction,
    output logic        outValid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outPcAdded     <= '0;
            outInstruction <= NOP_INSTR;
            outValid       <= 1'b0;
        end else if (bubble) begin
            outInstruction <= NOP_INSTR;
            outValid       <= 1'b0;
        end else if (load) begin
            outPcAdded     <= inPcAdded;
            outInstruction <= inInstruction;
            outValid       <= 1'b1;
        end
    end
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC, imem handshake, skid buffer and IF/ID register for the MIPS front end.
// Define FETCH_PERF_COUNT_EN to add the perfFetched/perfBubbles counters.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branchTarget,
    instruction_fetch_stage_if.master imem,
    output logic [31:0] outPcAdded,
    output logic [31:0] outInstruction,
    output logic        outValid
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] perfFetched,
    output logic [31:0] perfBubbles
`endif
);
    localparam logic [31:0] INC = 32'(PC_INC);

    fetchState_t state, nextState;
    logic [31:0] pc, pcPlus, skidPc, skidInstr, ldPc, ldInstr;
    logic        load, bubble;

    assign pcPlus        = pc + INC;
    assign imem.imemReq  = (state == FETCH);
    assign imem.imemAddr = pc;

    // Flush wins over everything; a stalled response parks in the skid buffer.
    always_comb begin
        nextState = state;
        load      = 1'b0;
        bubble    = 1'b0;
        ldPc      = pcPlus;
        ldInstr   = imem.imemData;
        if (flush) begin
            bubble    = 1'b1;
            nextState = FETCH;
        end else if (state == FETCH) begin
            if (!stall) begin
                load   = imem.imemReady;
                bubble = !imem.imemReady;
            end else if (imem.imemReady) begin
                nextState = HELD;
            end
        end else if (!stall) begin
            load      = 1'b1;
            ldPc      = skidPc;
            ldInstr   = skidInstr;
            nextState = FETCH;
        end
    end

    // pc stays at the fetch address while HELD, so pcPlus also advances past the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            skidPc    <= '0;
            skidInstr <= NOP_INSTR;
        end else begin
            state <= nextState;
            if (flush)
                pc <= branchTarget & PC_ALIGN_MASK;
            else if (load)
                pc <= pcPlus;
            if (flush) begin
                skidPc    <= '0;
                skidInstr <= NOP_INSTR;
            end else if (state == FETCH && stall && imem.imemReady) begin
                skidPc    <= pcPlus;
                skidInstr <= imem.imemData;
            end
        end
    end

    if_id_register ifId (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .bubble         (bubble),
        .inPcAdded      (ldPc),
        .inInstruction  (ldInstr),
        .outPcAdded     (outPcAdded),
        .outInstruction (outInstruction),
        .outValid       (outValid)
    );

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfFetched <= '0;
            perfBubbles <= '0;
        end else begin
            if (load)
                perfFetched <= perfFetched + 32'd1;
            if (bubble)
                perfBubbles <= perfBubbles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed-vector bench for instruction_fetch_stage.
// Honours FETCH_PERF_COUNT_EN when the design is built with it.
module tb_instruction_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branchTarget = '0;
    logic [31:0] outPcAdded, outInstruction;
    logic        outValid;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] perfFetched, perfBubbles;
`endif
    int compared = 0;
    int mismatched = 0;

    instruction_fetch_stage_if imem ();

    instruction_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .branchTarget   (branchTarget),
        .imem           (imem.master),
        .outPcAdded     (outPcAdded),
        .outInstruction (outInstruction),
        .outValid       (outValid)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .perfFetched    (perfFetched),
        .perfBubbles    (perfBubbles)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] instr(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic rdy, input logic [31:0] a);
        imem.imemReady = rdy;
        imem.imemData  = rdy ? instr(a) : 32'hDEAD_BEEF;
    endtask

    task automatic expectOut(input string tag, input logic [31:0] pcA, input logic [31:0] ins,
                             input logic v, input logic [31:0] addr, input logic req);
        check({tag, ".pcAdded"}, outPcAdded, pcA);
        check({tag, ".instr"}, outInstruction, ins);
        check({tag, ".valid"}, 32'(outValid), 32'(v));
        check({tag, ".addr"}, imem.imemAddr, addr);
        check({tag, ".req"}, 32'(imem.imemReq), 32'(req));
    endtask

    initial begin
        respond(1'b0, 32'h0);
        step;
        expectOut("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        respond(1'b1, 32'h0);
        step;
        expectOut("seq0", 32'h4, instr(32'h0), 1'b1, 32'h4, 1'b1);
        respond(1'b1, 32'h4);
        step;
        expectOut("seq1", 32'h8, instr(32'h4), 1'b1, 32'h8, 1'b1);
        respond(1'b0, 32'h0);
        step;
        expectOut("wait0", 32'h8, 32'h0, 1'b0, 32'h8, 1'b1);
        step;
        expectOut("wait1", 32'h8, 32'h0, 1'b0, 32'h8, 1'b1);
        respond(1'b1, 32'h8);
        step;
        expectOut("seq2", 32'hC, instr(32'h8), 1'b1, 32'hC, 1'b1);
        respond(1'b1, 32'hC);
        step;
        expectOut("seq3", 32'h10, instr(32'hC), 1'b1, 32'h10, 1'b1);
        stall = 1'b1;
        respond(1'b1, 32'h10);
        step;
        expectOut("stall0", 32'h10, instr(32'hC), 1'b1, 32'h10, 1'b0);
        respond(1'b0, 32'h0);
        step;
        expectOut("stall1", 32'h10, instr(32'hC), 1'b1, 32'h10, 1'b0);
        step;
        expectOut("stall2", 32'h10, instr(32'hC), 1'b1, 32'h10, 1'b0);
        stall = 1'b0;
        step;
        expectOut("release", 32'h14, instr(32'h10), 1'b1, 32'h14, 1'b1);
        flush = 1'b1;
        stall = 1'b1;
        branchTarget = 32'h0000_0103;
        respond(1'b1, 32'h14);
        step;
        expectOut("flush", 32'h14, 32'h0, 1'b0, 32'h100, 1'b1);
        flush = 1'b0;
        stall = 1'b0;
        respond(1'b1, 32'h100);
        step;
        expectOut("target", 32'h104, instr(32'h100), 1'b1, 32'h104, 1'b1);
        flush = 1'b1;
        branchTarget = 32'hFFFF_FFFF;
        respond(1'b0, 32'h0);
        step;
        expectOut("flushTop", 32'h104, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1);
        flush = 1'b0;
        respond(1'b1, 32'hFFFF_FFFC);
        step;
        expectOut("wrap", 32'h0, instr(32'hFFFF_FFFC), 1'b1, 32'h0, 1'b1);
        respond(1'b1, 32'h0);
        step;
        expectOut("afterWrap", 32'h4, instr(32'h0), 1'b1, 32'h4, 1'b1);
        respond(1'b0, 32'h0);
        step;
        expectOut("preReset", 32'h4, 32'h0, 1'b0, 32'h4, 1'b1);
`ifdef FETCH_PERF_COUNT_EN
        check("perfFetched", perfFetched, 32'd8);
        check("perfBubbles", perfBubbles, 32'd5);
`endif
        #1 rst_n = 1'b0;
        #1;
        expectOut("asyncReset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_PERF_COUNT_EN
        check("perfFetchedRst", perfFetched, 32'd0);
        check("perfBubblesRst", perfBubbles, 32'd0);
`endif
        #1 rst_n = 1'b1;
        respond(1'b1, 32'h0);
        step;
        expectOut("restart", 32'h4, instr(32'h0), 1'b1, 32'h4, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the 5-stage MIPS pipeline: owns the PC, issues instruction-memory fetches and drives the IF/ID pipeline register.
- Its outputs (outPcAdded, outInstruction) feed register-file read, sign extension and the control unit, whose results load the ID/EX register.
- Supports hazard-unit stall, branch-redirect flush, and an instruction memory that takes one or more cycles to answer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  branch taken (resolved in MEM): redirect and squash.
- branchTarget  input  32  redirect address, valid with flush.
- imemReq  output  1  fetch request to instruction memory.
- imemAddr  output  32  fetch address, equal to PC.
- imemReady  input  1  imemData valid this cycle for the current request.
- imemData  input  32  fetched instruction word.
- outPcAdded  output  32  IF/ID: fetch PC + PC_INC.
- outInstruction  output  32  IF/ID: instruction word.
- outValid  output  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC; state = FETCH.
  - outPcAdded = 0; outInstruction = 32'h0 (NOP); outValid = 0.
  - Skid buffer is emptied.
- imemAddr = pc (registered). imemReq = 1 in FETCH, 0 in HELD.
- Request rule: imemReq/imemAddr stay stable until imemReady is seen. The memory may answer in the same cycle or any later cycle.
- FSM states FETCH and HELD:
  - FETCH, imemReady=1, stall=0:
    - IF/ID loads {pc+PC_INC, imemData, valid=1}.
    - pc <= pc+PC_INC.
    - Latency is one clk from a ready response to the IF/ID update.
  - FETCH, imemReady=1, stall=1:
    - imemData and pc+PC_INC are captured in the skid buffer.
    - IF/ID holds; pc holds; next state HELD.
  - FETCH, imemReady=0, stall=0: IF/ID loads a bubble (outValid=0, outInstruction=0); outPcAdded holds.
  - FETCH, imemReady=0, stall=1: IF/ID holds.
  - HELD, stall=1: everything holds.
  - HELD, stall=0:
    - IF/ID loads the buffer with valid=1.
    - pc <= pc+PC_INC; next state FETCH.
- Flush has priority over stall and over imemReady:
  - pc <= {branchTarget[31:2], 2'b00}; the low bits are always forced to zero.
  - IF/ID loads a bubble; the skid buffer is discarded; next state FETCH.
  - A response arriving in the flush cycle is dropped.
  - A response still pending for the old address when flush arrives is abandoned. The next imemReady is taken as the answer for the new address, so the memory must drop an outstanding request when imemAddr changes.
- Arithmetic: 32-bit modulo. pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- outPcAdded is always the fetch PC + PC_INC of the instruction it accompanies, never the current pc.
- Reset mid-request: the outstanding response is ignored. Fetching restarts at RESET_PC on the first clk edge after rst_n deasserts.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined:
  - Adds output perfFetched[31:0], counting IF/ID loads with valid=1.
  - Adds output perfBubbles[31:0], counting cycles where IF/ID loads a bubble, including flush cycles.
  - Both reset to 0, wrap at 2^32, and hold while stall=1 with no flush.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - State encoding (FETCH=1'b0, HELD=1'b1).
  - NOP_INSTR = 32'h0000_0000.
  - PC_ALIGN_MASK = 32'hFFFF_FFFC.
- Sub-module if_id_register:
  - 32+32+1-bit register with load, hold (stall) and bubble (flush) controls, async active-low reset.
  - Instantiated once here.
- PC register, FSM and skid buffer stay in the top module.

Test Plan:
- Zero-wait memory, RESET_PC=0, 3 cycles, no stall: IF/ID shows (4, I0), (8, I1), (12, I2); outValid=1 each cycle; imemAddr 0, 4, 8.
- imemReady delayed 2 cycles on address 8: two bubbles (outValid=0, outInstruction=0); imemAddr held at 8; then (12, I2).
- Response at pc=16 while stall=1 for 3 cycles: IF/ID holds the prior instruction, state HELD, imemReq=0. On release, IF/ID = (20, I4) and imemAddr = 20 the next cycle.
- flush with branchTarget=32'h0000_0103 together with stall=1 and imemReady=1: outValid=0; pc=32'h0000_0100; the response is dropped; next fetch is at 0x100.
- pc=32'hFFFF_FFFC with a ready response: outPcAdded=32'h0; next imemAddr=0.
- rst_n pulled low mid-wait: outputs clear immediately; after release, imemAddr=RESET_PC. With FETCH_PERF_COUNT_EN defined, both counters read 0.
